// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the experiment 4 control unit:
// state codes, control bundle and the Moore output decode.
package exp4_unidade_controle_pkg;

    localparam int TIMEOUT_CICLOS_DEF = 5000;
    localparam int TMR_W_DEF          = 16;

    localparam logic [3:0] S_INICIAL     = 4'h0;
    localparam logic [3:0] S_PREPARACAO  = 4'h1;
    localparam logic [3:0] S_ESPERA      = 4'h2;
    localparam logic [3:0] S_REGISTRA    = 4'h4;
    localparam logic [3:0] S_COMPARACAO  = 4'h5;
    localparam logic [3:0] S_PROXIMO     = 4'h6;
    localparam logic [3:0] S_FIM_ACERTOU = 4'hA;
    localparam logic [3:0] S_FIM_ERROU   = 4'hE;
    localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;

    typedef enum logic [3:0] {
        INICIAL     = S_INICIAL,
        PREPARACAO  = S_PREPARACAO,
        ESPERA      = S_ESPERA,
        REGISTRA    = S_REGISTRA,
        COMPARACAO  = S_COMPARACAO,
        PROXIMO     = S_PROXIMO,
        FIM_ACERTOU = S_FIM_ACERTOU,
        FIM_ERROU   = S_FIM_ERROU,
        FIM_TIMEOUT = S_FIM_TIMEOUT
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctl_t;

    function automatic ctl_t saidas(estado_t e);
        ctl_t c;
        c = '0;
        case (e)
            PREPARACAO: begin
                c.zera_c = 1'b1;
                c.zera_r = 1'b1;
            end
            REGISTRA:    c.registra_r = 1'b1;
            PROXIMO:     c.conta_c = 1'b1;
            FIM_ACERTOU: begin
                c.pronto  = 1'b1;
                c.acertou = 1'b1;
            end
            FIM_ERROU: begin
                c.pronto = 1'b1;
                c.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                c.pronto  = 1'b1;
                c.timeout = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp4_unidade_controle_edge_detector.sv
// Registered rising-edge detector: pulso is high while sinal is 1
// and was 0 on the previous clock edge.
module exp4_unidade_controle_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic anterior;

    always_ff @(posedge clock) begin
        if (reset) begin
            anterior <= 1'b0;
        end else begin
            anterior <= sinal;
        end
    end

    assign pulso = sinal & ~anterior;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore control FSM for the experiment 4 datapath: counter,
// ROM, switch register and comparator, with a play timeout.
module exp4_unidade_controle
    import exp4_unidade_controle_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
    parameter int TMR_W          = TMR_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam logic [TMR_W-1:0] TMR_FIM = TMR_W'(TIMEOUT_CICLOS - 1);
    localparam bit TMR_EN = (TIMEOUT_CICLOS > 0);

    estado_t          estado;
    estado_t          proximo;
    ctl_t             ctl;
    logic [TMR_W-1:0] tmr;
    logic             jogada_pulso;
    logic             expirou;

    exp4_unidade_controle_edge_detector u_borda (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jogada_pulso)
    );

    assign expirou = TMR_EN && (tmr == TMR_FIM);

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:    proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: proximo = ESPERA;
            ESPERA: begin
                if (jogada_pulso) begin
                    proximo = REGISTRA;
                end else if (expirou) begin
                    proximo = FIM_TIMEOUT;
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA: proximo = COMPARACAO;
            COMPARACAO: begin
                // a mismatch ends the game even on the last address
                if (!chavesIgualMemoria) begin
                    proximo = FIM_ERROU;
                end else if (fimC) begin
                    proximo = FIM_ACERTOU;
                end else begin
                    proximo = PROXIMO;
                end
            end
            PROXIMO: proximo = ESPERA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT: proximo = iniciar ? PREPARACAO : estado;
            default:     proximo = INICIAL;
        endcase
    end

    // outputs are decoded from the next state so they leave a flop
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            ctl    <= '0;
            tmr    <= '0;
        end else begin
            estado <= proximo;
            ctl    <= saidas(proximo);
            if (estado == ESPERA && proximo == ESPERA) begin
                tmr <= tmr + 1'b1;
            end else begin
                tmr <= '0;
            end
        end
    end

    assign zeraC     = ctl.zera_c;
    assign contaC    = ctl.conta_c;
    assign zeraR     = ctl.zera_r;
    assign registraR = ctl.registra_r;
    assign pronto    = ctl.pronto;
    assign acertou   = ctl.acertou;
    assign errou     = ctl.errou;
    assign timeout   = ctl.timeout;
    assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for exp4_unidade_controle: a short-timeout and a default
// instance share stimulus and are checked against a game model.
module tb_exp4_unidade_controle;
    import exp4_unidade_controle_pkg::*;

    localparam int T_CURTO = 8;
    localparam int T_LONGO = TIMEOUT_CICLOS_DEF;

    typedef enum int {
        P_INI, P_PREP, P_ESP, P_REG, P_CMP,
        P_PROX, P_OK, P_ERR, P_TO
    } fase_t;

    typedef struct {
        fase_t f;
        int    w;
        logic  prev;
    } mod_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       mis_en;
    logic [3:0] mis_addr;
    logic [3:0] addr [2];
    logic [1:0] igual;
    logic [1:0] fim;
    logic [1:0] zc, cc, zr, rr, pr, ac, er, tmo;
    logic [3:0] db0, db1;

    mod_t m [2];
    int   n_conta [2];
    int   n_reg [2];
    int   n_cyc;
    int   checks;
    int   errors;

    // bench-side datapath: address counter, ROM compare and rco
    assign igual[0] = !(mis_en && addr[0] == mis_addr);
    assign igual[1] = !(mis_en && addr[1] == mis_addr);
    assign fim[0]   = (addr[0] == 4'hF);
    assign fim[1]   = (addr[1] == 4'hF);

    exp4_unidade_controle #(
        .TIMEOUT_CICLOS (T_CURTO),
        .TMR_W          (16)
    ) dut_curto (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (igual[0]),
        .fimC               (fim[0]),
        .zeraC              (zc[0]),
        .contaC             (cc[0]),
        .zeraR              (zr[0]),
        .registraR          (rr[0]),
        .pronto             (pr[0]),
        .acertou            (ac[0]),
        .errou              (er[0]),
        .timeout            (tmo[0]),
        .db_estado          (db0)
    );

    exp4_unidade_controle #(
        .TIMEOUT_CICLOS (T_LONGO),
        .TMR_W          (16)
    ) dut_longo (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (igual[1]),
        .fimC               (fim[1]),
        .zeraC              (zc[1]),
        .contaC             (cc[1]),
        .zeraR              (zr[1]),
        .registraR          (rr[1]),
        .pronto             (pr[1]),
        .acertou            (ac[1]),
        .errou              (er[1]),
        .timeout            (tmo[1]),
        .db_estado          (db1)
    );

    function automatic mod_t passo(mod_t s, int t, logic rst,
                                   logic ini, logic jog,
                                   logic eq, logic fc);
        mod_t r;
        logic borda;
        r     = s;
        borda = jog && !s.prev;
        r.prev = rst ? 1'b0 : jog;
        if (rst) begin
            r.f = P_INI;
            r.w = 0;
        end else begin
            case (s.f)
                P_INI:  if (ini) r.f = P_PREP;
                P_PREP: begin
                    r.f = P_ESP;
                    r.w = 0;
                end
                P_ESP: begin
                    if (borda) r.f = P_REG;
                    else if (t > 0 && s.w + 1 == t) r.f = P_TO;
                    else r.w = s.w + 1;
                end
                P_REG:  r.f = P_CMP;
                P_CMP:  r.f = !eq ? P_ERR : (fc ? P_OK : P_PROX);
                P_PROX: begin
                    r.f = P_ESP;
                    r.w = 0;
                end
                default: if (ini) r.f = P_PREP;
            endcase
        end
        return r;
    endfunction

    // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [7:0] ctl_of(fase_t f);
        case (f)
            P_PREP:  return 8'b1010_0000;
            P_REG:   return 8'b0001_0000;
            P_PROX:  return 8'b0100_0000;
            P_OK:    return 8'b0000_1100;
            P_ERR:   return 8'b0000_1010;
            P_TO:    return 8'b0000_1001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] code_of(fase_t f);
        case (f)
            P_PREP:  return S_PREPARACAO;
            P_ESP:   return S_ESPERA;
            P_REG:   return S_REGISTRA;
            P_CMP:   return S_COMPARACAO;
            P_PROX:  return S_PROXIMO;
            P_OK:    return S_FIM_ACERTOU;
            P_ERR:   return S_FIM_ERROU;
            P_TO:    return S_FIM_TIMEOUT;
            default: return S_INICIAL;
        endcase
    endfunction

    always @(posedge clock) begin
        m[0]  <= passo(m[0], T_CURTO, reset, iniciar, jogada,
                       igual[0], fim[0]);
        m[1]  <= passo(m[1], T_LONGO, reset, iniciar, jogada,
                       igual[1], fim[1]);
        n_cyc <= n_cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (zc[i]) addr[i] <= 4'h0;
            else if (cc[i]) addr[i] <= addr[i] + 4'h1;
            n_conta[i] <= n_conta[i] + int'(cc[i]);
            n_reg[i]   <= n_reg[i] + int'(rr[i]);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compara();
        logic [11:0] act;
        logic [11:0] exp;
        for (int i = 0; i < 2; i++) begin
            act = {zc[i], cc[i], zr[i], rr[i], pr[i], ac[i],
                   er[i], tmo[i], (i == 0) ? db0 : db1};
            exp = {ctl_of(m[i].f), code_of(m[i].f)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model dut%0d cycle %0d: got %h, expected %h",
                         i, n_cyc, act, exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            compara();
        end
    endtask

    task automatic play(input bit last);
        jogada = 1'b1;
        cyc(1);
        jogada = 1'b0;
        cyc(last ? 2 : 3);
    endtask

    int t0;
    int bc0, br0, bc1, br1;

    initial begin
        checks   = 0;
        errors   = 0;
        n_cyc    = 0;
        reset    = 1'b1;
        iniciar  = 1'b0;
        jogada   = 1'b0;
        mis_en   = 1'b0;
        mis_addr = 4'h0;
        cyc(2);
        chk("reset_db", int'(db0), 0);
        chk("reset_pronto", int'(pr[0]), 0);
        reset = 1'b0;
        cyc(1);
        chk("idle_db", int'(db1), 0);

        // full winning game at minimum latency
        bc0 = n_conta[0];
        br0 = n_reg[0];
        t0  = n_cyc;
        iniciar = 1'b1;
        cyc(1);
        chk("prep_db", int'(db0), 1);
        chk("prep_zeraC", int'(zc[0]), 1);
        iniciar = 1'b0;
        cyc(1);
        for (int k = 0; k < 16; k++) play(k == 15);
        chk("win_latency", n_cyc - t0, 65);
        chk("win_db", int'(db0), 'hA);
        chk("win_acertou", int'(ac[0]), 1);
        chk("win_errou", int'(er[0]), 0);
        chk("win_pronto", int'(pr[0]), 1);
        chk("win_contaC", n_conta[0] - bc0, 15);
        chk("win_registraR", n_reg[0] - br0, 16);

        // mismatch at the fourth play
        bc0 = n_conta[0];
        iniciar = 1'b1;
        cyc(1);
        iniciar  = 1'b0;
        mis_en   = 1'b1;
        mis_addr = 4'h3;
        cyc(1);
        for (int k = 0; k < 3; k++) play(1'b0);
        play(1'b1);
        chk("err_db", int'(db0), 'hE);
        chk("err_errou", int'(er[0]), 1);
        chk("err_pronto", int'(pr[0]), 1);
        chk("err_acertou", int'(ac[0]), 0);
        chk("err_contaC", n_conta[0] - bc0, 3);

        // restart from FIM_ERROU; iniciar in ESPERA is ignored
        iniciar = 1'b1;
        cyc(1);
        chk("restart_db", int'(db0), 1);
        iniciar = 1'b0;
        mis_en  = 1'b0;
        cyc(1);
        chk("restart_esp", int'(db0), 2);
        iniciar = 1'b1;
        cyc(1);
        chk("ini_in_esp", int'(db0), 2);
        iniciar = 1'b0;
        for (int k = 0; k < 16; k++) play(k == 15);
        chk("rewin_db", int'(db1), 'hA);

        // timeout after 8 idle ESPERA cycles on the short instance
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        cyc(1);
        cyc(7);
        chk("to_esp8", int'(db0), 2);
        cyc(1);
        chk("to_db", int'(db0), 'hD);
        chk("to_flag", int'(tmo[0]), 1);
        chk("to_pronto", int'(pr[0]), 1);
        chk("to_long_db", int'(db1), 2);

        // edge on the 8th ESPERA cycle beats the timeout
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        cyc(1);
        cyc(7);
        jogada = 1'b1;
        cyc(1);
        chk("edge_wins", int'(db0), 4);
        jogada = 1'b0;
        cyc(3);
        chk("edge_back", int'(db0), 2);

        // held press counts once
        bc1 = n_conta[1];
        br1 = n_reg[1];
        jogada = 1'b1;
        cyc(20);
        jogada = 1'b0;
        chk("hold_reg", n_reg[1] - br1, 1);
        chk("hold_conta", n_conta[1] - bc1, 1);
        chk("hold_db", int'(db1), 2);
        chk("hold_short_to", int'(db0), 'hD);
        cyc(2);

        // reset in COMPARACAO at address 5
        reset = 1'b1;
        cyc(1);
        reset   = 1'b0;
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        cyc(1);
        for (int k = 0; k < 5; k++) play(1'b0);
        jogada = 1'b1;
        cyc(1);
        jogada = 1'b0;
        cyc(1);
        chk("mid_cmp_db", int'(db0), 5);
        chk("mid_addr", int'(addr[0]), 5);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_db", int'(db0), 0);
        chk("mid_rst_out", int'({zc, cc, zr, rr, pr, ac, er, tmo}), 0);
        reset   = 1'b0;
        iniciar = 1'b1;
        cyc(1);
        chk("mid_prep_db", int'(db1), 1);
        chk("mid_prep_z", int'({zc[1], zr[1]}), 3);
        iniciar = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
